reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters SHALL be ROB_SIZE=64 (ring depth), ISSUE_PORTS=3 (CDB ports), REG_SIZE=32 (data width), NUM_TAGS=64 (physical tags), ARCH_REGS=32 (architectural registers).
REQ-002 Derived widths SHALL be ROB_SIZE_LOG2=$clog2(ROB_SIZE) and NUM_TAGS_LOG2=$clog2(NUM_TAGS).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 stall_in  in  1  high blocks retirement.
REQ-006 alloc_valid  in  1  allocate one entry this cycle.
REQ-007 alloc_rd_arch  in  $clog2(ARCH_REGS)  architectural destination.
REQ-008 alloc_tag_rd  in  NUM_TAGS_LOG2  physical destination tag.
REQ-009 rob_tail  out  ROB_SIZE_LOG2  index the current alloc receives.
REQ-010 rob_full  out  1  all ROB_SIZE entries occupied.
REQ-011 lookup_tag_rs[0:1]  in  NUM_TAGS_LOG2 each  source tags from rename.
REQ-012 rob_data_rs[0:1], rob_contains_rs[0:1], rob_ready_rs[0:1]  out  REG_SIZE/1/1  lookup results.
REQ-013 cdb_tags, cdb_data, cdb_rob_index, cdb_valid [0:ISSUE_PORTS-1]  in  NUM_TAGS_LOG2/REG_SIZE/ROB_SIZE_LOG2/1  FU results.
REQ-014 retire_valid, retire_rd_arch, retire_tag, retire_data  out  1/5/NUM_TAGS_LOG2/REG_SIZE  committed instruction to ARF.

Function
REQ-015 Entry SHALL hold valid, done, rd_arch, tag_rd, data; ring SHALL use head, tail, and count (ROB_SIZE_LOG2+1 bits).
REQ-016 rob_full SHALL equal (count==ROB_SIZE); rob_tail SHALL equal tail, combinationally.
REQ-017 alloc_valid && !rob_full: entry[tail] <= {valid=1, done=0, rd_arch, tag_rd, data=0}, tail increments modulo ROB_SIZE.
REQ-018 alloc_valid && rob_full: request dropped, no state change.
REQ-019 Each cdb_valid[p] SHALL set done=1 and data=cdb_data[p] at entry[cdb_rob_index[p]] if that entry is valid; writes to invalid entries ignored.
REQ-020 Ports writing the same index in one cycle: highest p wins.
REQ-021 Retire: head valid && done && !stall_in -> next edge clears entry[head], head increments, count decrements, retire_* registered from that entry with retire_valid=1 for one cycle; otherwise retire_valid=0, other retire_* hold.
REQ-022 Max one allocation and one retirement per cycle; simultaneous alloc+retire leaves count unchanged.
REQ-023 Retirement SHALL be strictly in allocation order; a CDB write to head is retireable the following cycle (no same-cycle bypass).
REQ-024 Lookup (combinational), per source k: tag 0 -> contains=0, ready=1, data=0.
REQ-025 Otherwise, matching valid entry: contains=1; ready=done; data=entry.data. On multiple matches the youngest (nearest tail) SHALL win.
REQ-026 Same-cycle CDB bypass: valid CDB port whose cdb_tags matches the found entry's tag -> ready=1, data=cdb_data (highest port wins).
REQ-027 No matching entry: contains=0, ready=1, data=0 (value comes from ARF).
REQ-028 Head/tail wrap from ROB_SIZE-1 to 0 without loss; empty (count==0) SHALL never assert retire_valid.

Reset
REQ-029 rst low at a clock edge: head=0, tail=0, count=0, all valid/done=0, data=0, retire_valid=0, retire_rd_arch/tag/data=0; rob_full=0, rob_tail=0.
REQ-030 Reset mid-operation SHALL discard all in-flight entries and take priority over same-cycle alloc, CDB, and retire.

Structure
REQ-031 Shared package SHALL hold ROB_SIZE, NUM_TAGS, ISSUE_PORTS, REG_SIZE, ARCH_REGS and the rob_entry_t packed struct, shared with the issue queue.
REQ-032 Youngest-match search SHALL be one sub-module, rob_tag_lookup, instantiated twice (one per source).

Verification
REQ-033 Reset, alloc tag 5/rd 3, CDB p0 index 0 data 0xDEAD -> retire_valid=1 two cycles after CDB edge, retire_rd_arch=3, retire_data=0xDEAD.
REQ-034 Fill 64 entries -> rob_full=1, 65th alloc dropped, rob_tail stays 0; one retire+alloc same cycle -> count stays 64.
REQ-035 Complete index 1 before index 0 -> no retire until index 0 done; then index 0 and index 1 retire on consecutive cycles.
REQ-036 Lookup tag 7 pending while CDB p2 broadcasts tag 7 data 0x42 same cycle -> contains=1, ready=1, data=0x42; lookup tag 9 absent -> contains=0, ready=1; tag 0 -> ready=1.
REQ-037 Retire 70 instructions with stall_in pulsed high 3 cycles -> head wraps 63->0, no retire during stall, order preserved.
REQ-038 rst low with 10 entries in flight and alloc_valid=1 -> next cycle count=0, rob_tail=0, retire_valid=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants and entry layout, also used by the issue queue.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE       = 64;
  localparam int unsigned ISSUE_PORTS    = 3;
  localparam int unsigned REG_SIZE       = 32;
  localparam int unsigned NUM_TAGS       = 64;
  localparam int unsigned ARCH_REGS      = 32;
  localparam int unsigned ROB_SIZE_LOG2  = $clog2(ROB_SIZE);
  localparam int unsigned NUM_TAGS_LOG2  = $clog2(NUM_TAGS);
  localparam int unsigned ARCH_REGS_LOG2 = $clog2(ARCH_REGS);

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic [ARCH_REGS_LOG2-1:0] rd_arch;
    logic [NUM_TAGS_LOG2-1:0]  tag_rd;
    logic [REG_SIZE-1:0]       data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_tag_lookup.sv
// Source-operand lookup: youngest valid ROB entry holding a tag, with same-cycle CDB bypass.
module rob_tag_lookup
  import reorder_buffer_pkg::*;
(
  input  logic [NUM_TAGS_LOG2-1:0] tag,
  input  logic [ROB_SIZE_LOG2-1:0] head,
  input  rob_entry_t               entries   [0:ROB_SIZE-1],
  input  logic                     cdb_valid [0:ISSUE_PORTS-1],
  input  logic [NUM_TAGS_LOG2-1:0] cdb_tags  [0:ISSUE_PORTS-1],
  input  logic [REG_SIZE-1:0]      cdb_data  [0:ISSUE_PORTS-1],
  output logic                     contains,
  output logic                     ready,
  output logic [REG_SIZE-1:0]      data
);

  logic                     hit;
  logic [ROB_SIZE_LOG2-1:0] hit_idx;
  logic [ROB_SIZE_LOG2-1:0] idx;

  // Walk oldest to youngest so the last match kept is the one nearest the tail.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      idx = head + ROB_SIZE_LOG2'(i);
      if (entries[idx].valid && entries[idx].tag_rd == tag) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  always_comb begin
    contains = 1'b0;
    ready    = 1'b1;
    data     = '0;
    if (tag != '0 && hit) begin
      contains = 1'b1;
      ready    = entries[hit_idx].done;
      data     = entries[hit_idx].data;
      for (int p = 0; p < ISSUE_PORTS; p++) begin
        if (cdb_valid[p] && cdb_tags[p] == tag) begin
          ready = 1'b1;
          data  = cdb_data[p];
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement ring for renamed instructions; ROB_SIZE must be a power of two.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE      = reorder_buffer_pkg::ROB_SIZE,
  parameter int unsigned ISSUE_PORTS   = reorder_buffer_pkg::ISSUE_PORTS,
  parameter int unsigned REG_SIZE      = reorder_buffer_pkg::REG_SIZE,
  parameter int unsigned NUM_TAGS      = reorder_buffer_pkg::NUM_TAGS,
  parameter int unsigned ARCH_REGS     = reorder_buffer_pkg::ARCH_REGS,
  parameter int unsigned ROB_SIZE_LOG2 = $clog2(ROB_SIZE),
  parameter int unsigned NUM_TAGS_LOG2 = $clog2(NUM_TAGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_in,
  input  logic                         alloc_valid,
  input  logic [$clog2(ARCH_REGS)-1:0] alloc_rd_arch,
  input  logic [NUM_TAGS_LOG2-1:0]     alloc_tag_rd,
  output logic [ROB_SIZE_LOG2-1:0]     rob_tail,
  output logic                         rob_full,
  input  logic [NUM_TAGS_LOG2-1:0]     lookup_tag_rs   [0:1],
  output logic [REG_SIZE-1:0]          rob_data_rs     [0:1],
  output logic                         rob_contains_rs [0:1],
  output logic                         rob_ready_rs    [0:1],
  input  logic [NUM_TAGS_LOG2-1:0]     cdb_tags        [0:ISSUE_PORTS-1],
  input  logic [REG_SIZE-1:0]          cdb_data        [0:ISSUE_PORTS-1],
  input  logic [ROB_SIZE_LOG2-1:0]     cdb_rob_index   [0:ISSUE_PORTS-1],
  input  logic                         cdb_valid       [0:ISSUE_PORTS-1],
  output logic                         retire_valid,
  output logic [$clog2(ARCH_REGS)-1:0] retire_rd_arch,
  output logic [NUM_TAGS_LOG2-1:0]     retire_tag,
  output logic [REG_SIZE-1:0]          retire_data
);

  import reorder_buffer_pkg::rob_entry_t;

  localparam int unsigned CountW = ROB_SIZE_LOG2 + 1;

  rob_entry_t               entries_q [0:ROB_SIZE-1];
  rob_entry_t               entries_d [0:ROB_SIZE-1];
  logic [ROB_SIZE_LOG2-1:0] head_q, head_d;
  logic [ROB_SIZE_LOG2-1:0] tail_q, tail_d;
  logic [CountW-1:0]        count_q, count_d;
  logic                     do_alloc;
  logic                     do_retire;

  assign rob_full  = (count_q == CountW'(ROB_SIZE));
  assign rob_tail  = tail_q;
  assign do_alloc  = alloc_valid && !rob_full;
  assign do_retire = entries_q[head_q].valid && entries_q[head_q].done && !stall_in;

  // CDB writes first, then alloc at tail, then the retire clear at head; the retire uses
  // the pre-edge entry so a CDB write to head only becomes retireable next cycle.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    for (int p = 0; p < ISSUE_PORTS; p++) begin
      if (cdb_valid[p] && entries_q[cdb_rob_index[p]].valid) begin
        entries_d[cdb_rob_index[p]].done = 1'b1;
        entries_d[cdb_rob_index[p]].data = cdb_data[p];
      end
    end
    if (do_alloc) begin
      entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, rd_arch: alloc_rd_arch,
                            tag_rd: alloc_tag_rd, data: '0};
      tail_d            = tail_q + 1'b1;
    end
    if (do_retire) begin
      entries_d[head_q] = '0;
      head_d            = head_q + 1'b1;
    end
    unique case ({do_alloc, do_retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid   <= 1'b0;
      retire_rd_arch <= '0;
      retire_tag     <= '0;
      retire_data    <= '0;
    end else begin
      entries_q    <= entries_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      retire_valid <= do_retire;
      if (do_retire) begin
        retire_rd_arch <= entries_q[head_q].rd_arch;
        retire_tag     <= entries_q[head_q].tag_rd;
        retire_data    <= entries_q[head_q].data;
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_lookup
    rob_tag_lookup u_lookup (
      .tag       (lookup_tag_rs[k]),
      .head      (head_q),
      .entries   (entries_q),
      .cdb_valid (cdb_valid),
      .cdb_tags  (cdb_tags),
      .cdb_data  (cdb_data),
      .contains  (rob_contains_rs[k]),
      .ready     (rob_ready_rs[k]),
      .data      (rob_data_rs[k])
    );
  end

endmodule
